// File: rtl/id_ex_elastic_reg_if.sv
// ID->EX boundary bus: decode-side beat, forwarding lanes, flush and execute-side entry.
// The decode/hazard side uses the master view; the stage register uses the slave view.
interface id_ex_elastic_reg_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int CTRL_W  = 12
);
    logic                      in_valid;
    logic                      in_ready;
    logic [XLEN-1:0]           in_pc;
    logic [XLEN-1:0]           in_pc4;
    logic [XLEN-1:0]           in_imm;
    logic [NUM_SRC*XLEN-1:0]   in_src;
    logic [REG_AW-1:0]         in_wr;
    logic [CTRL_W-1:0]         in_ctrl;
    logic [NUM_SRC-1:0]        cap_fw_en;
    logic [NUM_SRC*XLEN-1:0]   cap_fw_data;
    logic [NUM_SRC-1:0]        hold_fw_en;
    logic [NUM_SRC*XLEN-1:0]   hold_fw_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           out_pc;
    logic [XLEN-1:0]           out_pc4;
    logic [XLEN-1:0]           out_imm;
    logic [NUM_SRC*XLEN-1:0]   out_src;
    logic [REG_AW-1:0]         out_wr;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [1:0]                occupancy;

    modport master (
        output in_valid, in_pc, in_pc4, in_imm, in_src, in_wr, in_ctrl,
        output cap_fw_en, cap_fw_data, hold_fw_en, hold_fw_data, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_pc4, out_imm, out_src, out_wr, out_ctrl, occupancy
    );

    modport slave (
        input  in_valid, in_pc, in_pc4, in_imm, in_src, in_wr, in_ctrl,
        input  cap_fw_en, cap_fw_data, hold_fw_en, hold_fw_data, flush, out_ready,
        output in_ready, out_valid, out_pc, out_pc4, out_imm, out_src, out_wr, out_ctrl, occupancy
    );
endinterface

// File: rtl/id_ex_elastic_reg.sv
// ID->EX elastic stage register: OUT entry plus one skid entry, flush, capture-time and
// late (held-entry) operand forwarding. in_ready comes purely from registered state.
module id_ex_elastic_reg #(
    parameter int XLEN               = 32,
    parameter int NUM_SRC            = 2,
    parameter int REG_AW             = 5,
    parameter int CTRL_W             = 12,
    parameter bit ZERO_DATA_ON_FLUSH = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    id_ex_elastic_reg_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0]         pc;
        logic [XLEN-1:0]         pc4;
        logic [XLEN-1:0]         imm;
        logic [NUM_SRC*XLEN-1:0] src;
        logic [REG_AW-1:0]       wr;
        logic [CTRL_W-1:0]       ctrl;
    } entry_t;

    entry_t     out_reg, out_next;
    entry_t     skid_reg, skid_next;
    entry_t     beat;
    logic       out_valid_reg, out_valid_next;
    logic       skid_valid_reg, skid_valid_next;
    logic [1:0] occupancy_reg;
    logic [NUM_SRC*XLEN-1:0] cap_src;
    logic       acc;
    logic       con;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cap
            assign cap_src[gi*XLEN +: XLEN] = bus.cap_fw_en[gi] ? bus.cap_fw_data[gi*XLEN +: XLEN]
                                                                 : bus.in_src[gi*XLEN +: XLEN];
        end
    endgenerate

    assign beat.pc   = bus.in_pc;
    assign beat.pc4  = bus.in_pc4;
    assign beat.imm  = bus.in_imm;
    assign beat.src  = cap_src;
    assign beat.wr   = bus.in_wr;
    assign beat.ctrl = bus.in_ctrl;

    assign acc = bus.in_valid & ~skid_valid_reg & ~bus.flush;
    assign con = out_valid_reg & bus.out_ready;

    always_comb begin
        out_next        = out_reg;
        skid_next       = skid_reg;
        out_valid_next  = out_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (bus.flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
            if (ZERO_DATA_ON_FLUSH) begin
                out_next  = '0;
                skid_next = '0;
            end else begin
                out_next.ctrl  = '0;
                skid_next.ctrl = '0;
            end
        end else if (skid_valid_reg && con) begin
            out_next        = skid_reg;
            skid_valid_next = 1'b0;
        end else if (!out_valid_reg || con) begin
            if (acc) begin
                out_next       = beat;
                out_valid_next = 1'b1;
            end else begin
                // An empty OUT entry must look like a bubble downstream.
                out_valid_next = 1'b0;
                out_next.ctrl  = '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.hold_fw_en[i]) begin
                    out_next.src[i*XLEN +: XLEN] = bus.hold_fw_data[i*XLEN +: XLEN];
                end
            end
            if (acc) begin
                skid_next       = beat;
                skid_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            occupancy_reg  <= 2'd0;
        end else begin
            out_reg        <= out_next;
            skid_reg       <= skid_next;
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            occupancy_reg  <= {1'b0, out_valid_next} + {1'b0, skid_valid_next};
        end
    end

    assign bus.in_ready  = ~skid_valid_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_pc    = out_reg.pc;
    assign bus.out_pc4   = out_reg.pc4;
    assign bus.out_imm   = out_reg.imm;
    assign bus.out_src   = out_reg.src;
    assign bus.out_wr    = out_reg.wr;
    assign bus.out_ctrl  = out_reg.ctrl;
    assign bus.occupancy = occupancy_reg;
endmodule
